// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg
//   Shared definitions for the USB transmit CRC path:
//   - tx_state_e       : framing FSM states (IDLE, DATA, CRC_LO, CRC_HI)
//   - CRC16_INIT       : CRC-16/USB seed
//   - CRC16_XOROUT     : final XOR applied before the CRC goes on the wire
//   - CRC16_POLY_REFL  : bit-reversed form of the 0x8005 polynomial, used by
//                        the LSB-first (reflected) shift register
package usb_crc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CRC_LO = 2'd2,
        CRC_HI = 2'd3
    } tx_state_e;

    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_XOROUT    = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

endpackage

// File: rtl/crc16_usb_byte_step.sv
// crc16_usb_byte_step
//   Purely combinational one-byte update of the reflected CRC-16/USB register.
//   Ports:
//     crc      [15:0] in   current CRC register value (before final XOR)
//     data     [7:0]  in   byte to fold in, LSB transmitted first
//     crc_next [15:0] out  register value after absorbing the byte
module crc16_usb_byte_step
    import usb_crc_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    // stage[0] folds the whole byte into the low bits at once; each following
    // stage is one shift of the reflected LFSR, so eight stages consume the byte.
    logic [15:0] stage [0:8];

    assign stage[0] = crc ^ {8'h00, data};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][0]
                               ? ({1'b0, stage[gi][15:1]} ^ CRC16_POLY_REFL)
                               :  {1'b0, stage[gi][15:1]};
        end
    endgenerate

    assign crc_next = stage[8];

endmodule

// File: rtl/usb_tx_crc_append.sv
// usb_tx_crc_append
//   Forwards a payload byte stream to the line encoder and appends the
//   CRC-16/USB (low byte first, then high byte). Also generates zero-length
//   packets (CRC bytes only) on request, reports the payload length of each
//   completed packet and flags packets longer than MAX_PAYLOAD.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     s_data/s_valid/s_last/s_ready   payload input stream
//     zlp_req              one-cycle request for a zero-length packet
//     m_data/m_valid/m_last/m_ready   output byte stream (single register)
//     pkt_done             high during the handshake of the CRC high byte
//     pkt_len  [10:0]      payload count of the last completed packet (sat. 2047)
//     len_err              sticky over-length flag for the current/last packet
module usb_tx_crc_append
    import usb_crc_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        zlp_req,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        pkt_done,
    output logic [10:0] pkt_len,
    output logic        len_err
);

    localparam logic [31:0] MAX_PAYLOAD_U = 32'(MAX_PAYLOAD);
    localparam logic [10:0] COUNT_MAX     = 11'h7FF;

    tx_state_e   state_reg;
    logic [15:0] crc_reg;
    logic [10:0] count_reg;
    logic [7:0]  m_data_reg;
    logic        m_valid_reg;
    logic        m_last_reg;
    logic [10:0] pkt_len_reg;
    logic        len_err_reg;

    logic        out_free;
    logic        in_idle;
    logic        accept;
    logic        last_hs;
    logic [15:0] crc_seed;
    logic [15:0] crc_step;
    logic [10:0] count_next;
    logic        over_limit;
    logic [15:0] crc_out;

    // The output register can take a new byte when it is empty or being drained.
    assign out_free = !m_valid_reg || m_ready;
    assign in_idle  = (state_reg == IDLE);

    // A zero-length request in IDLE takes priority over payload, so the source
    // is held off for that cycle.
    assign s_ready = out_free && ((in_idle && !zlp_req) || (state_reg == DATA));
    assign accept  = s_valid && s_ready;
    assign last_hs = m_valid_reg && m_last_reg && m_ready;

    // The first byte of a packet is folded into a fresh seed rather than the
    // leftover CRC of the previous packet.
    assign crc_seed = in_idle ? CRC16_INIT : crc_reg;

    crc16_usb_byte_step u_crc_step (
        .crc      (crc_seed),
        .data     (s_data),
        .crc_next (crc_step)
    );

    assign count_next = in_idle               ? 11'd1
                      : (count_reg == COUNT_MAX) ? COUNT_MAX
                      : count_reg + 11'd1;
    assign over_limit = 32'(count_next) > MAX_PAYLOAD_U;
    assign crc_out    = crc_reg ^ CRC16_XOROUT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            crc_reg     <= CRC16_INIT;
            count_reg   <= 11'd0;
            m_data_reg  <= 8'h00;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            pkt_len_reg <= 11'd0;
            len_err_reg <= 1'b0;
        end else begin
            // count_reg still belongs to the finishing packet here, even if a
            // new packet starts on this very edge.
            if (last_hs) begin
                pkt_len_reg <= count_reg;
            end

            // Drained unless one of the loads below refills it.
            if (out_free) begin
                m_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (zlp_req) begin
                        crc_reg     <= CRC16_INIT;
                        count_reg   <= 11'd0;
                        len_err_reg <= 1'b0;
                        state_reg   <= CRC_LO;
                    end else if (accept) begin
                        crc_reg     <= crc_step;
                        count_reg   <= count_next;
                        len_err_reg <= over_limit;
                        m_data_reg  <= s_data;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        state_reg   <= s_last ? CRC_LO : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        crc_reg     <= crc_step;
                        count_reg   <= count_next;
                        if (over_limit) begin
                            len_err_reg <= 1'b1;
                        end
                        m_data_reg  <= s_data;
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        if (s_last) begin
                            state_reg <= CRC_LO;
                        end
                    end
                end
                CRC_LO: begin
                    if (out_free) begin
                        m_data_reg  <= crc_out[7:0];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b0;
                        state_reg   <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (out_free) begin
                        m_data_reg  <= crc_out[15:8];
                        m_valid_reg <= 1'b1;
                        m_last_reg  <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_data   = m_data_reg;
    assign m_valid  = m_valid_reg;
    assign m_last   = m_last_reg;
    assign pkt_done = last_hs;
    assign pkt_len  = pkt_len_reg;
    assign len_err  = len_err_reg;

endmodule

// File: tb/tb_usb_tx_crc_append.sv
module tb_usb_tx_crc_append;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        zlp_req = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        pkt_done;
    logic [10:0] pkt_len;
    logic        len_err;

    usb_tx_crc_append #(.MAX_PAYLOAD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .zlp_req  (zlp_req),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .pkt_done (pkt_done),
        .pkt_len  (pkt_len),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q [$];        // {last, data}
    logic [7:0]  pkt_mem [0:15];
    logic        len_err_after [0:15];
    int          first_acc_cyc = -1;
    int          last_hs_cyc = -1;
    int          pkt_done_cnt = 0;
    bit          rand_ready = 0;

    // Reference CRC-16/USB, processed one input bit at a time.
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ pkt_mem[i][b]) c = (c >> 1) ^ 16'hA001;
                else                      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic load_ascii;
        for (int i = 0; i < 9; i++) pkt_mem[i] = 8'h31 + 8'(i);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    // Output monitor: pops the scoreboard on every output handshake, checks
    // pkt_done against the handshake and output stability while stalled.
    task automatic run_monitor;
        logic       stall_prev;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] exp;
        stall_prev = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if (pkt_done !== (m_valid && m_ready && m_last)) begin
                    errors++;
                    $display("FAIL pkt_done_pulse: got %b, expected %b at cyc %0d",
                             pkt_done, (m_valid && m_ready && m_last), cyc);
                end
                if (stall_prev) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                                 m_valid, m_data, m_last, prev_data, prev_last);
                    end
                end
                if (m_valid && m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL out_byte: got d=%h l=%b, expected no byte", m_data, m_last);
                    end else begin
                        exp = exp_q.pop_front();
                        if ({m_last, m_data} !== exp) begin
                            errors++;
                            $display("FAIL out_byte: got d=%h l=%b, expected d=%h l=%b",
                                     m_data, m_last, exp[7:0], exp[8]);
                        end else begin
                            $display("out byte d=%h l=%b ok", m_data, m_last);
                        end
                    end
                    if (m_last) last_hs_cyc = cyc;
                end
                if (pkt_done) pkt_done_cnt++;
                stall_prev = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    endtask

    // Presents pkt_mem[0..n-1]; closes with s_last and queues the CRC if
    // close=1. zlp_req is raised alongside byte index zlp_at. s_valid is left
    // as-is at the end so packets can follow back to back.
    task automatic send_pkt(input int n, input bit close, input logic [15:0] crc_exp,
                            input int zlp_at);
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            s_data  = pkt_mem[i];
            s_valid = 1'b1;
            s_last  = close && (i == n - 1);
            zlp_req = (i == zlp_at);
            exp_q.push_back({1'b0, pkt_mem[i]});
            acc   = 0;
            guard = 0;
            while (!acc && guard < 200) begin
                #1;
                acc = s_ready;
                if (acc && i == 0) first_acc_cyc = cyc;
                step();
                guard++;
                if (acc) len_err_after[i] = len_err;
            end
            zlp_req = 1'b0;
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept for byte %0d, expected accept", i);
            end
        end
        s_last = 1'b0;
        if (close) begin
            exp_q.push_back({1'b0, crc_exp[7:0]});
            exp_q.push_back({1'b1, crc_exp[15:8]});
        end
    endtask

    task automatic wait_drain;
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            step();
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        step();
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || pkt_done !== 1'b0 ||
            pkt_len !== 11'd0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b done=%b len=%0d err=%b, expected all 0",
                     m_valid, m_data, m_last, pkt_done, pkt_len, len_err);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready: got %b, expected 1", s_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_crc_check;
        int done0;
        done0 = pkt_done_cnt;
        load_ascii();
        send_pkt(9, 1, 16'hB4C8, -1);
        s_valid = 1'b0;
        wait_drain();
        checks++;
        if (pkt_len !== 11'd9) begin
            errors++;
            $display("FAIL crc_check_len: got %0d, expected 9", pkt_len);
        end
        checks++;
        if (pkt_done_cnt - done0 !== 1) begin
            errors++;
            $display("FAIL crc_check_done: got %0d pulses, expected 1", pkt_done_cnt - done0);
        end
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL crc_check_len_err: got %b, expected 1 (9 > 4)", len_err);
        end
        $display("test_crc_check done");
    endtask

    task automatic test_zlp;
        int done0;
        done0 = pkt_done_cnt;
        zlp_req = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL zlp_priority: got s_ready=%b, expected 0", s_ready);
        end
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h00});
        step();
        zlp_req = 1'b0;
        s_valid = 1'b0;
        wait_drain();
        checks++;
        if (pkt_len !== 11'd0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL zlp_status: got len=%0d err=%b, expected len=0 err=0", pkt_len, len_err);
        end
        checks++;
        if (pkt_done_cnt - done0 !== 1) begin
            errors++;
            $display("FAIL zlp_done: got %0d pulses, expected 1", pkt_done_cnt - done0);
        end
        $display("test_zlp done");
    endtask

    task automatic test_stall;
        rand_ready = 1;
        load_ascii();
        send_pkt(9, 1, 16'hB4C8, 3);   // zlp_req mid-packet must be ignored
        s_valid = 1'b0;
        wait_drain();
        rand_ready = 0;
        m_ready = 1'b1;
        step();
        checks++;
        if (pkt_len !== 11'd9) begin
            errors++;
            $display("FAIL stall_len: got %0d, expected 9", pkt_len);
        end
        $display("test_stall done");
    endtask

    task automatic test_len_err;
        for (int i = 0; i < 5; i++) pkt_mem[i] = 8'hA0 + 8'(i);
        send_pkt(5, 1, crc_model(5), -1);
        s_valid = 1'b0;
        checks++;
        if (len_err_after[0] !== 1'b0) begin
            errors++;
            $display("FAIL len_err_clear: got %b after first byte, expected 0", len_err_after[0]);
        end
        checks++;
        if (len_err_after[3] !== 1'b0) begin
            errors++;
            $display("FAIL len_err_at_max: got %b after 4th byte, expected 0", len_err_after[3]);
        end
        checks++;
        if (len_err_after[4] !== 1'b1) begin
            errors++;
            $display("FAIL len_err_over: got %b after 5th byte, expected 1", len_err_after[4]);
        end
        wait_drain();
        checks++;
        if (len_err !== 1'b1 || pkt_len !== 11'd5) begin
            errors++;
            $display("FAIL len_err_sticky: got err=%b len=%0d, expected err=1 len=5", len_err, pkt_len);
        end
        $display("test_len_err done");
    endtask

    task automatic test_reset_mid;
        load_ascii();
        send_pkt(3, 0, 16'h0000, -1);
        s_valid = 1'b0;
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_pending: got %0d bytes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_abort: got v=%b l=%b s_ready=%b, expected v=0 l=0 s_ready=1",
                     m_valid, m_last, s_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        send_pkt(9, 1, 16'hB4C8, -1);
        s_valid = 1'b0;
        wait_drain();
        checks++;
        if (pkt_len !== 11'd9) begin
            errors++;
            $display("FAIL reset_mid_len: got %0d, expected 9", pkt_len);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back;
        pkt_mem[0] = 8'h11;
        pkt_mem[1] = 8'h22;
        send_pkt(2, 1, crc_model(2), -1);
        pkt_mem[0] = 8'h33;
        pkt_mem[1] = 8'h44;
        pkt_mem[2] = 8'h55;
        send_pkt(3, 1, crc_model(3), -1);
        s_valid = 1'b0;
        checks++;
        if (first_acc_cyc !== last_hs_cyc) begin
            errors++;
            $display("FAIL back_to_back: got first accept cyc %0d, expected %0d (prev m_last handshake)",
                     first_acc_cyc, last_hs_cyc);
        end
        wait_drain();
        checks++;
        if (pkt_len !== 11'd3) begin
            errors++;
            $display("FAIL back_to_back_len: got %0d, expected 3", pkt_len);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_crc_check();
        test_zlp();
        test_stall();
        test_len_err();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d bytes pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_crc_append.md
USB_TX_CRC_APPEND -- requirements
Module: usb_tx_crc_append

Interface
REQ-001 Parameter MAX_PAYLOAD, default 1023, is the maximum payload byte count per packet before len_err is raised.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_data  input  8  payload byte from the packet source.
REQ-005 s_valid  input  1  s_data is valid.
REQ-006 s_last  input  1  s_data is the final payload byte of the packet.
REQ-007 s_ready  output  1  the block accepts s_data this cycle.
REQ-008 zlp_req  input  1  single-cycle request to send a zero-length packet, which carries the CRC bytes only.
REQ-009 m_data  output  8  byte stream to the line encoder: payload bytes, then the CRC low byte, then the CRC high byte.
REQ-010 m_valid, m_last  output  1 each  m_data is valid; m_data is the final byte of the packet (the CRC high byte).
REQ-011 m_ready  input  1  the sink accepts m_data this cycle.
REQ-012 pkt_done  output  1  one-cycle pulse when the CRC high byte handshakes.
REQ-013 pkt_len  output  11  payload byte count of the last completed packet; saturates at 2047.
REQ-014 len_err  output  1  sticky flag: the current or last packet exceeded MAX_PAYLOAD.

Function
REQ-015 The CRC SHALL be CRC-16/USB: polynomial 0x8005, initial value 0xFFFF, reflected input and output, final XOR 0xFFFF.
REQ-016 The transmitted CRC SHALL be the low byte first, then the high byte.
REQ-017 The FSM states SHALL be IDLE, DATA, CRC_LO and CRC_HI.
REQ-018 The output stage is a single register; "free" means (!m_valid || m_ready).
REQ-019 s_ready SHALL equal free in IDLE and DATA, and SHALL be 0 in CRC_LO and CRC_HI.
REQ-020 An accepted byte (s_valid && s_ready) SHALL appear on m_data exactly one cycle later, with m_valid=1 and m_last=0.
REQ-021 IDLE, byte accepted: the CRC SHALL be seeded to 0xFFFF and updated with the byte in the same cycle, and the byte count set to 1.
REQ-022 IDLE, byte accepted: the next state SHALL be CRC_LO if s_last=1, else DATA.
REQ-023 DATA, byte accepted: the CRC SHALL be updated and the count incremented (saturating).
REQ-024 DATA, byte accepted: the next state SHALL be CRC_LO if s_last=1.
REQ-025 CRC_LO, when free: the output SHALL load ~crc[7:0] with m_last=0, and the state SHALL go to CRC_HI.
REQ-026 CRC_HI, when free: the output SHALL load ~crc[15:8] with m_last=1, and the state SHALL go to IDLE.
REQ-027 pkt_done SHALL pulse, and pkt_len SHALL update, on the cycle the m_last byte handshakes.
REQ-028 zlp_req in IDLE: the CRC SHALL be 0xFFFF, the count 0, and the state SHALL go to CRC_LO, giving output bytes 0x00 0x00.
REQ-029 zlp_req and s_valid together in IDLE: zlp_req SHALL win, and s_ready SHALL be 0 that cycle.
REQ-030 zlp_req outside IDLE SHALL be ignored.
REQ-031 len_err SHALL set when the count would exceed MAX_PAYLOAD; the bytes SHALL still be forwarded.
REQ-032 len_err SHALL clear on the first byte or zlp_req of the next packet.
REQ-033 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-034 A packet may start in the same cycle the previous m_last byte handshakes (back-to-back packets).

Reset
REQ-035 On reset: state=IDLE, m_valid=0, m_data=0x00, m_last=0, pkt_done=0, pkt_len=0, len_err=0, CRC=0xFFFF, count=0.
REQ-036 Reset asserted mid-packet SHALL abort the packet immediately; no CRC bytes are emitted after release.

Structure
REQ-037 A shared package usb_crc_pkg SHALL hold the FSM state enum, CRC16_INIT=16'hFFFF and CRC16_XOROUT=16'hFFFF.
REQ-038 The per-byte CRC update SHALL be one combinational sub-module, crc16_usb_byte_step (inputs crc[15:0], data[7:0]; output next crc[15:0]).
REQ-039 The CRC register, counter and FSM SHALL reside in usb_tx_crc_append.

Verification
REQ-040 Scenario: ASCII "123456789" (0x31..0x39, s_last on 0x39), m_ready=1 -> m_data 0x31..0x39, 0xC8, 0xB4; m_last on 0xB4; pkt_len=9; pkt_done one pulse.
REQ-041 Scenario: zlp_req pulse in IDLE -> m_data 0x00, 0x00; m_last on the second byte; pkt_len=0.
REQ-042 Scenario: "123456789" with m_ready toggled randomly -> the same byte sequence, no byte lost or duplicated, outputs stable while stalled.
REQ-043 Scenario: MAX_PAYLOAD=4, send 5 bytes -> len_err=1 after the 5th accept; all 5 bytes plus CRC emitted; len_err cleared on the next packet's first byte.
REQ-044 Scenario: rst_n pulsed after 3 bytes of a packet -> m_valid=0 and state IDLE at once; the next "123456789" packet yields CRC 0xC8, 0xB4.
REQ-045 Scenario: two back-to-back packets with s_valid held high -> the second packet's first byte is accepted in the cycle the first packet's CRC high byte handshakes.
